// File: rtl/seg_share_ctrl.sv
// seg_share_ctrl: round-robin sharing of one 4-digit multiplexed 7-seg
// display among three requesters, each supplying four BCD digits.
// Ports:
//   clk           system clock (posedge)
//   rst           asynchronous active-low reset
//   req[2:0]      level requests, bit i = requester i
//   val0/1/2      BCD digits per requester, [15:12] = leftmost
//   grant[2:0]    one-hot display owner, 0 when idle
//   seg_S[7:0]    segments {dp,g..a}, active-low
//   com_s[3:0]    digit commons, active-low, bit 3 = leftmost
//   busy          high while a grant is active
module seg_share_ctrl #(
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_FRAMES = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [15:0] val2,
    output logic [2:0]  grant,
    output logic [7:0]  seg_S,
    output logic [3:0]  com_s,
    output logic        busy
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(HOLD_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] HOLD     = FW'(HOLD_FRAMES);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t        state, state_n;
    logic [2:0]    grant_n;
    logic [1:0]    last, last_n;
    logic [1:0]    slot, slot_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [FW-1:0] frm, frm_n, frm_inc;
    logic [7:0]    seg_n;
    logic [3:0]    com_n;
    logic [2:0]    pick;
    logic          load;

    // Round-robin pick: search starts one past the last owner.
    function automatic logic [2:0] rr_pick(input logic [2:0] r,
                                           input logic [1:0] lo);
        logic [2:0] g;
        g = 3'b000;
        unique case (lo)
            2'd0: begin
                if (r[1])      g = 3'b010;
                else if (r[2]) g = 3'b100;
                else if (r[0]) g = 3'b001;
            end
            2'd1: begin
                if (r[2])      g = 3'b100;
                else if (r[0]) g = 3'b001;
                else if (r[1]) g = 3'b010;
            end
            default: begin
                if (r[0])      g = 3'b001;
                else if (r[1]) g = 3'b010;
                else if (r[2]) g = 3'b100;
            end
        endcase
        return g;
    endfunction

    function automatic logic [1:0] idx(input logic [2:0] g);
        logic [1:0] i;
        i = 2'd0;
        if (g[1]) i = 2'd1;
        if (g[2]) i = 2'd2;
        return i;
    endfunction

    function automatic logic [15:0] val_of(input logic [2:0] g,
                                           input logic [15:0] v0,
                                           input logic [15:0] v1,
                                           input logic [15:0] v2);
        logic [15:0] v;
        v = 16'h0000;
        if (g[0]) v = v0;
        if (g[1]) v = v1;
        if (g[2]) v = v2;
        return v;
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v,
                                       input logic [1:0] s);
        logic [3:0] n;
        unique case (s)
            2'd0:    n = v[15:12];
            2'd1:    n = v[11:8];
            2'd2:    n = v[7:4];
            default: n = v[3:0];
        endcase
        return n;
    endfunction

    function automatic logic [7:0] dec(input logic [3:0] d);
        logic [7:0] p;
        unique case (d)
            4'd0:    p = 8'hC0;
            4'd1:    p = 8'hF9;
            4'd2:    p = 8'hA4;
            4'd3:    p = 8'hB0;
            4'd4:    p = 8'h99;
            4'd5:    p = 8'h92;
            4'd6:    p = 8'h82;
            4'd7:    p = 8'hF8;
            4'd8:    p = 8'h80;
            4'd9:    p = 8'h90;
            default: p = 8'hBF;
        endcase
        return p;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= 3'b000;
            last  <= 2'd2;
            slot  <= 2'd0;
            cnt   <= '0;
            frm   <= '0;
            seg_S <= 8'hFF;
            com_s <= 4'b1111;
        end else begin
            state <= state_n;
            grant <= grant_n;
            last  <= last_n;
            slot  <= slot_n;
            cnt   <= cnt_n;
            frm   <= frm_n;
            seg_S <= seg_n;
            com_s <= com_n;
        end
    end

    assign busy    = |grant;
    assign frm_inc = (frm >= HOLD) ? frm : frm + FW'(1);

    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last;
        slot_n  = slot;
        cnt_n   = cnt;
        frm_n   = frm;
        seg_n   = seg_S;
        com_n   = com_s;
        pick    = rr_pick(req, last);
        load    = 1'b0;

        unique case (state)
            IDLE: begin
                seg_n  = 8'hFF;
                com_n  = 4'b1111;
                slot_n = 2'd0;
                cnt_n  = '0;
                frm_n  = '0;
                if (|req) load = 1'b1;
            end
            SHOW: begin
                if (cnt != CNT_LAST) begin
                    cnt_n = cnt + CW'(1);
                end else if (slot != 2'd3) begin
                    // Nibble is captured here and held all slot.
                    cnt_n  = '0;
                    slot_n = slot + 2'd1;
                    com_n  = ~(4'b1000 >> slot_n);
                    seg_n  = dec(nib(val_of(grant, val0, val1, val2),
                                     slot_n));
                end else if (!(|(req & grant))) begin
                    // Owner gone: hand off or fall back to idle.
                    if (|pick) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                        grant_n = 3'b000;
                        slot_n  = 2'd0;
                        cnt_n   = '0;
                        frm_n   = '0;
                        seg_n   = 8'hFF;
                        com_n   = 4'b1111;
                    end
                end else if (frm_inc >= HOLD && |(req & ~grant)) begin
                    // Owner is searched last, so pick is another one.
                    load = 1'b1;
                end else begin
                    cnt_n  = '0;
                    slot_n = 2'd0;
                    frm_n  = frm_inc;
                    com_n  = 4'b0111;
                    seg_n  = dec(nib(val_of(grant, val0, val1, val2),
                                     2'd0));
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            state_n = SHOW;
            grant_n = pick;
            last_n  = idx(pick);
            slot_n  = 2'd0;
            cnt_n   = '0;
            frm_n   = '0;
            com_n   = 4'b0111;
            seg_n   = dec(nib(val_of(pick, val0, val1, val2), 2'd0));
        end
    end

endmodule

// File: tb/tb_seg_share_ctrl.sv
// Directed bench for seg_share_ctrl with SCAN_DIV=4, HOLD_FRAMES=2.
// Offsets in comments are cycles since the current grant began.
module tb_seg_share_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [15:0] val0, val1, val2;
    logic [2:0]  grant;
    logic [7:0]  seg_S;
    logic [3:0]  com_s;
    logic        busy;

    int errs = 0;
    int checks = 0;

    seg_share_ctrl #(
        .SCAN_DIV    (4),
        .HOLD_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .val0  (val0),
        .val1  (val1),
        .val2  (val2),
        .grant (grant),
        .seg_S (seg_S),
        .com_s (com_s),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] g,
                           input logic [3:0] c, input logic [7:0] s);
        chk({tag, ".grant"}, 16'(grant), 16'(g));
        chk({tag, ".com"}, 16'(com_s), 16'(c));
        chk({tag, ".seg"}, 16'(seg_S), 16'(s));
        chk({tag, ".busy"}, 16'(busy), 16'(|g));
    endtask

    initial begin
        rst  = 1'b0;
        req  = 3'b111;
        val0 = 16'h9ABF;
        val1 = 16'h1234;
        val2 = 16'h5678;
        tick(2);
        chk_out("rst", 3'b000, 4'b1111, 8'hFF);

        // Release; requester 0 wins first.
        rst = 1'b1;
        tick(1);
        chk_out("a0", 3'b001, 4'b0111, 8'h90);
        tick(4);
        chk_out("a4", 3'b001, 4'b1011, 8'hBF);
        tick(1);
        val0 = 16'h915F;
        tick(1);
        chk_out("a6_hold", 3'b001, 4'b1011, 8'hBF);
        tick(2);
        chk_out("a8", 3'b001, 4'b1101, 8'h92);
        tick(4);
        chk_out("a12", 3'b001, 4'b1110, 8'hBF);
        tick(4);
        chk_out("a16", 3'b001, 4'b0111, 8'h90);
        tick(15);
        chk_out("a31", 3'b001, 4'b1110, 8'hBF);
        tick(1);
        chk_out("a32_rot", 3'b010, 4'b0111, 8'hF9);

        // Owner 1 alone scans 1234.
        req = 3'b010;
        tick(4);
        chk_out("b36", 3'b010, 4'b1011, 8'hA4);
        tick(4);
        chk_out("b40", 3'b010, 4'b1101, 8'hB0);
        tick(4);
        chk_out("b44", 3'b010, 4'b1110, 8'h99);
        tick(4);
        chk_out("b48_keep", 3'b010, 4'b0111, 8'hF9);
        tick(8);
        chk_out("b56", 3'b010, 4'b1101, 8'hB0);

        // Reset in slot 2 blanks immediately.
        tick(1);
        rst = 1'b0;
        #1;
        chk_out("rst_mid", 3'b000, 4'b1111, 8'hFF);
        req = 3'b001;
        rst = 1'b1;
        tick(1);
        chk_out("c0", 3'b001, 4'b0111, 8'h90);
        tick(4);
        chk_out("c4", 3'b001, 4'b1011, 8'hF9);

        // Owner drops in slot 1; frame completes, then idle.
        tick(1);
        req = 3'b000;
        tick(10);
        chk_out("c15", 3'b001, 4'b1110, 8'hBF);
        tick(1);
        chk_out("c16_idle", 3'b000, 4'b1111, 8'hFF);
        tick(3);
        chk_out("c19_idle", 3'b000, 4'b1111, 8'hFF);

        // Fresh reset, requesters 0 and 2 alternate every 2 frames.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        req = 3'b101;
        tick(1);
        chk_out("d0", 3'b001, 4'b0111, 8'h90);
        tick(16);
        chk("d16.grant", 16'(grant), 16'(3'b001));
        tick(15);
        chk("d31.grant", 16'(grant), 16'(3'b001));
        tick(1);
        chk_out("d32", 3'b100, 4'b0111, 8'h92);
        tick(31);
        chk("d63.grant", 16'(grant), 16'(3'b100));
        tick(1);
        chk_out("d64", 3'b001, 4'b0111, 8'h90);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
